// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounce four active-low buttons and generate the controller update tick
//
// Purpose:
//   Cleans the four raw active-low board keys. Each key has a 2-flop synchronizer and a
//   debouncer. The debouncer changes its output only after the synchronized input has
//   disagreed with it for DEB_CYCLES consecutive clocks. A free-running divider makes the
//   periodic one-clock update pulse. any_pressed flags that at least one debounced key is down.
//
// Optional feature (macro HOLD_ACCEL_EN):
//   If a key is held for ACCEL_TICKS update ticks, the tick period halves to UPDATE_DIV/2.
//   Without the macro the period is always UPDATE_DIV.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   key_raw[3:0] in   raw keys, active-low, asynchronous ([0]=angleup [1]=angledown [2]=powerup [3]=powerdown)
//   angleup      out  debounced key_raw[0], active-low
//   angledown    out  debounced key_raw[1], active-low
//   powerup      out  debounced key_raw[2], active-low
//   powerdown    out  debounced key_raw[3], active-low
//   update       out  one-clock high pulse per tick period
//   any_pressed  out  high while any debounced key is low (registered, one clock behind)

module button_conditioner #(
  parameter int DEB_CYCLES  = 500000,
  parameter int UPDATE_DIV  = 2500000,
  parameter int ACCEL_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw,
  output logic       angleup,
  output logic       angledown,
  output logic       powerup,
  output logic       powerdown,
  output logic       update,
  output logic       any_pressed
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(UPDATE_DIV);

  // Elaboration-time parameter sanity checks.
  if (UPDATE_DIV < 2) begin : g_bad_div
    $error("UPDATE_DIV must be at least 2");
  end
  if (ACCEL_TICKS < 0) begin : g_bad_accel
    $error("ACCEL_TICKS must not be negative");
  end

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          update_q, update_d;
  logic          any_q, any_d;
  logic [TW-1:0] tick_last;
  logic          tick_wrap;

`ifdef HOLD_ACCEL_EN
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
        // DEB_CYCLES consecutive disagreeing samples seen: accept the new level.
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end

`ifdef HOLD_ACCEL_EN
    tick_last = (hold_q == HW'(ACCEL_TICKS)) ? TW'(UPDATE_DIV / 2 - 1) : TW'(UPDATE_DIV - 1);
    hold_d    = hold_q;
    if (!any_q) begin
      hold_d = '0;
    end else if (update_q && (hold_q != HW'(ACCEL_TICKS))) begin
      hold_d = hold_q + 1'b1;
    end
`else
    tick_last = TW'(UPDATE_DIV - 1);
`endif

    // Use >= so that a shortened limit still wraps on the next cycle
    // when the counter is already past it.
    tick_wrap  = (tick_cnt_q >= tick_last);
    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    update_d   = tick_wrap;
    any_d      = ~&deb_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      tick_cnt_q <= '0;
      update_q   <= 1'b0;
      any_q      <= 1'b0;
`ifdef HOLD_ACCEL_EN
      hold_q     <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      tick_cnt_q <= tick_cnt_d;
      update_q   <= update_d;
      any_q      <= any_d;
`ifdef HOLD_ACCEL_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign angleup     = deb_q[0];
  assign angledown   = deb_q[1];
  assign powerup     = deb_q[2];
  assign powerdown   = deb_q[3];
  assign update      = update_q;
  assign any_pressed = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with a behavioural reference model

module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int DIV = 10;
  localparam int ACC = 2;

  logic       clk;
  logic       rst;
  logic [3:0] key_raw;
  logic       angleup, angledown, powerup, powerdown, update, any_pressed;

  button_conditioner #(
    .DEB_CYCLES (DEB),
    .UPDATE_DIV (DIV),
    .ACCEL_TICKS(ACC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .angleup    (angleup),
    .angledown  (angledown),
    .powerup    (powerup),
    .powerdown  (powerdown),
    .update     (update),
    .any_pressed(any_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Expected vector layout: {any_pressed, update, powerdown, powerup, angledown, angleup}
  logic [5:0] exp_q [$];

  // Reference model: state is expressed as "edges since reset release",
  // "history of raw samples" and "time of last tick".
  logic [3:0] raw_hist [$];
  logic [3:0] m_out;
  logic       m_upd, m_any;
  int         m_edge, m_last_tick, m_hold;

  function automatic logic [3:0] raw_at(input int e);
    // Synchronizer flops hold 1 before the first post-reset sample.
    if (e < 1) return 4'hF;
    return raw_hist[e - 1];
  endfunction

  task automatic model_edge(input logic rst_s, input logic [3:0] raw_s);
    logic [3:0] new_out;
    logic       new_upd, new_any;
    int         per;
    if (!rst_s) begin
      m_out = 4'hF; m_upd = 1'b0; m_any = 1'b0;
      m_edge = 0; m_last_tick = 0; m_hold = 0;
      raw_hist.delete();
      return;
    end
    m_edge++;
    // A bit flips when the DEB most recent synchronized samples all show the opposite level.
    new_out = m_out;
    for (int b = 0; b < 4; b++) begin
      bit all_opp = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        logic [3:0] s;
        s = raw_at(m_edge - 2 - k);
        if (s[b] == m_out[b]) all_opp = 1'b0;
      end
      if (all_opp) new_out[b] = ~m_out[b];
    end
    raw_hist.push_back(raw_s);
    new_any = (m_out != 4'hF);
    per = DIV;
`ifdef HOLD_ACCEL_EN
    if (m_hold == ACC) per = DIV / 2;
    if (!m_any) m_hold = 0;
    else if (m_upd && m_hold < ACC) m_hold++;
`endif
    new_upd = ((m_edge - m_last_tick) >= per);
    if (new_upd) m_last_tick = m_edge;
    m_out = new_out; m_upd = new_upd; m_any = new_any;
  endtask

  task automatic step(input logic rst_v, input logic [3:0] k);
    rst     = rst_v;
    key_raw = k;
    @(posedge clk);
    model_edge(rst_v, k);
    exp_q.push_back({m_any, m_upd, m_out});
    #1;
  endtask

  task automatic hold_for(input logic rst_v, input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) step(rst_v, k);
  endtask

  // Monitor: every cycle the DUT presents a full output vector; compare against the queue head.
  always @(negedge clk) begin
    logic [5:0] act, exp_v;
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act   = {any_pressed, update, powerdown, powerup, angledown, angleup};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: actual {any,upd,pd,pu,ad,au}=%b required=%b", cyc, act, exp_v);
      end
    end
  end

  initial begin
    rst     = 1'b0;
    key_raw = 4'b0000;
    // Reset with all keys pressed: outputs must stay idle.
    hold_for(1'b0, 4'b0000, 3);
    // angleup pressed steady from release.
    hold_for(1'b1, 4'b1110, 12);
    hold_for(1'b1, 4'b1111, 8);
    // Three-cycle glitch on powerup must be rejected.
    hold_for(1'b1, 4'b1011, 3);
    hold_for(1'b1, 4'b1111, 6);
    // Idle: tick spacing.
    hold_for(1'b1, 4'b1111, 15);
    // Simultaneous angleup + angledown.
    hold_for(1'b1, 4'b1100, 10);
    hold_for(1'b1, 4'b1111, 8);
    // Hold powerdown long enough to reach acceleration, then release.
    hold_for(1'b1, 4'b0111, 60);
    hold_for(1'b1, 4'b1111, 40);
    // Reset mid-operation with a debounce in progress.
    hold_for(1'b1, 4'b1101, 3);
    hold_for(1'b0, 4'b1101, 2);
    hold_for(1'b1, 4'b1101, 12);
    // Randomized segments with occasional short resets.
    for (int seg = 0; seg < 80; seg++) begin
      logic [3:0] k;
      int         len;
      k   = 4'($urandom);
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) hold_for(1'b0, k, $urandom_range(1, 2));
      hold_for(1'b1, k, len);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
